// File: rtl/model_tensor_differentiation.sv
// Tensor differentiation: d[i][j][l] = (x[i][j][l] - x[i][j][l-1]) / PERIOD, one element at a time,
// using a restoring divider that retires one quotient bit per cycle.
module model_tensor_differentiation #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_SCALAR_ENABLE,
  output logic                 DATA_OUT_SCALAR_ENABLE,
  output logic                 DATA_OUT_VECTOR_ENABLE,
  output logic                 DATA_OUT_MATRIX_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] LENGTH_IN,
  input  logic [DATA_SIZE-1:0] PERIOD_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int CW = $clog2(DATA_SIZE) + 1;

  // CONTROL_SIZE only keeps the parameter list aligned with sibling blocks.
  if (CONTROL_SIZE < 0) begin : g_control_unused
  end

  typedef enum logic [1:0] {
    STARTER_STATE,
    INPUT_STATE,
    DIVIDE_STATE,
    OUTPUT_STATE
  } state_t;

  state_t state, state_next;

  logic [DATA_SIZE-1:0] size_i_q, size_j_q, length_q, period_q;
  logic [DATA_SIZE-1:0] index_i, index_j, index_l;
  logic [DATA_SIZE-1:0] previous;
  logic [DATA_SIZE-1:0] quo, rem;
  logic                 neg;
  logic [CW-1:0]        div_cnt;
  logic                 ready_pending;

  logic                 zero_size, l_last, j_last, i_last, last_elem, div_done;
  logic [DATA_SIZE-1:0] in_diff, in_mag;
  logic [DATA_SIZE:0]   rem_shift;
  logic [DATA_SIZE-1:0] rem_trial;
  logic                 take;

  assign zero_size = (size_i_q == '0) || (size_j_q == '0) || (length_q == '0);
  assign l_last    = index_l == length_q - DATA_SIZE'(1);
  assign j_last    = index_j == size_j_q - DATA_SIZE'(1);
  assign i_last    = index_i == size_i_q - DATA_SIZE'(1);
  assign last_elem = l_last && j_last && i_last;
  assign div_done  = div_cnt == CW'(DATA_SIZE - 1);

  // Divide the magnitude; the sign is reapplied on output for truncation toward zero.
  assign in_diff   = DATA_IN - previous;
  assign in_mag    = in_diff[DATA_SIZE-1] ? ('0 - in_diff) : in_diff;
  assign rem_shift = {rem, quo[DATA_SIZE-1]};
  assign take      = rem_shift >= {1'b0, period_q};
  assign rem_trial = rem_shift[DATA_SIZE-1:0] - period_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= STARTER_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      STARTER_STATE: if (START) state_next = INPUT_STATE;
      INPUT_STATE: begin
        if (zero_size)                  state_next = STARTER_STATE;
        else if (DATA_IN_SCALAR_ENABLE) state_next = DIVIDE_STATE;
      end
      DIVIDE_STATE:  if (div_done) state_next = OUTPUT_STATE;
      OUTPUT_STATE:  state_next = last_elem ? STARTER_STATE : INPUT_STATE;
      default:       state_next = STARTER_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      READY                  <= 1'b0;
      DATA_OUT               <= '0;
      DATA_OUT_SCALAR_ENABLE <= 1'b0;
      DATA_OUT_VECTOR_ENABLE <= 1'b0;
      DATA_OUT_MATRIX_ENABLE <= 1'b0;
      size_i_q               <= '0;
      size_j_q               <= '0;
      length_q               <= '0;
      period_q               <= '0;
      index_i                <= '0;
      index_j                <= '0;
      index_l                <= '0;
      previous               <= '0;
      quo                    <= '0;
      rem                    <= '0;
      neg                    <= 1'b0;
      div_cnt                <= '0;
      ready_pending          <= 1'b0;
    end else begin
      DATA_OUT_SCALAR_ENABLE <= 1'b0;
      DATA_OUT_VECTOR_ENABLE <= 1'b0;
      DATA_OUT_MATRIX_ENABLE <= 1'b0;
      ready_pending          <= 1'b0;
      READY                  <= ready_pending;
      case (state)
        STARTER_STATE: begin
          if (START) begin
            size_i_q <= SIZE_I_IN;
            size_j_q <= SIZE_J_IN;
            length_q <= LENGTH_IN;
            period_q <= PERIOD_IN;
            index_i  <= '0;
            index_j  <= '0;
            index_l  <= '0;
            previous <= '0;
          end
        end
        INPUT_STATE: begin
          if (zero_size) begin
            READY <= 1'b1;
          end else if (DATA_IN_SCALAR_ENABLE) begin
            previous <= DATA_IN;
            quo      <= in_mag;
            neg      <= in_diff[DATA_SIZE-1];
            rem      <= '0;
            div_cnt  <= '0;
          end
        end
        DIVIDE_STATE: begin
          rem     <= take ? rem_trial : rem_shift[DATA_SIZE-1:0];
          quo     <= {quo[DATA_SIZE-2:0], take};
          div_cnt <= div_cnt + CW'(1);
        end
        OUTPUT_STATE: begin
          DATA_OUT               <= (period_q == '0) ? '0 : (neg ? ('0 - quo) : quo);
          DATA_OUT_SCALAR_ENABLE <= 1'b1;
          DATA_OUT_VECTOR_ENABLE <= l_last;
          DATA_OUT_MATRIX_ENABLE <= l_last && j_last;
          if (l_last) begin
            index_l  <= '0;
            previous <= '0;
            if (j_last) begin
              index_j <= '0;
              if (i_last) begin
                index_i       <= '0;
                ready_pending <= 1'b1;
              end else begin
                index_i <= index_i + DATA_SIZE'(1);
              end
            end else begin
              index_j <= index_j + DATA_SIZE'(1);
            end
          end else begin
            index_l <= index_l + DATA_SIZE'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_model_tensor_differentiation.sv
// Self-checking bench for model_tensor_differentiation: scoreboard of expected
// {vector, matrix, data} plus accept cycles, checked on every scalar output pulse.
module tb_model_tensor_differentiation;

  localparam int W  = 64;
  localparam int EW = W + 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         READY;
  logic         DATA_IN_SCALAR_ENABLE;
  logic         DATA_OUT_SCALAR_ENABLE;
  logic         DATA_OUT_VECTOR_ENABLE;
  logic         DATA_OUT_MATRIX_ENABLE;
  logic [W-1:0] SIZE_I_IN, SIZE_J_IN, LENGTH_IN, PERIOD_IN, DATA_IN, DATA_OUT;

  model_tensor_differentiation #(.DATA_SIZE(W), .CONTROL_SIZE(4)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .START                  (START),
    .READY                  (READY),
    .DATA_IN_SCALAR_ENABLE  (DATA_IN_SCALAR_ENABLE),
    .DATA_OUT_SCALAR_ENABLE (DATA_OUT_SCALAR_ENABLE),
    .DATA_OUT_VECTOR_ENABLE (DATA_OUT_VECTOR_ENABLE),
    .DATA_OUT_MATRIX_ENABLE (DATA_OUT_MATRIX_ENABLE),
    .SIZE_I_IN              (SIZE_I_IN),
    .SIZE_J_IN              (SIZE_J_IN),
    .LENGTH_IN              (LENGTH_IN),
    .PERIOD_IN              (PERIOD_IN),
    .DATA_IN                (DATA_IN),
    .DATA_OUT               (DATA_OUT)
  );

  // clock / cycle count
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  logic [W-1:0]  stim_q[$];
  int            n_out   = 0;
  int            n_ready = 0;
  logic [EW-1:0] mon_e;
  int            mon_a;

  // scoreboard monitor
  always @(negedge CLK) begin
    if (READY === 1'b1) n_ready++;
    if (DATA_OUT_SCALAR_ENABLE === 1'b1) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: data=%h with empty expected queue", DATA_OUT);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        if ({DATA_OUT_VECTOR_ENABLE, DATA_OUT_MATRIX_ENABLE, DATA_OUT} !== mon_e) begin
          errors++;
          $display("FAIL output: got vec=%b mat=%b data=%h, want vec=%b mat=%b data=%h",
                   DATA_OUT_VECTOR_ENABLE, DATA_OUT_MATRIX_ENABLE, DATA_OUT,
                   mon_e[W+1], mon_e[W], mon_e[W-1:0]);
        end
        checks++;
        if (cyc - mon_a !== W + 1) begin
          errors++;
          $display("FAIL latency: got %0d cycles, want %0d", cyc - mon_a, W + 1);
        end
      end
    end
  end

  // drivers; every task starts and ends just after a falling edge
  function automatic logic [W-1:0] model_div(input logic [W-1:0] d, input logic [W-1:0] per);
    logic [W-1:0] mag, q;
    if (per == '0) return '0;
    mag = d[W-1] ? (~d + 64'd1) : d;
    q   = mag / per;
    return d[W-1] ? (~q + 64'd1) : q;
  endfunction

  task automatic run_tensor(input int ni, input int nj, input int nl,
                            input logic [W-1:0] per, input bit inject);
    int           n0, r0, k, pulse_cyc;
    logic [W-1:0] prev, x, d;
    n0   = n_out;
    r0   = n_ready;
    prev = '0;
    SIZE_I_IN = W'(ni); SIZE_J_IN = W'(nj); LENGTH_IN = W'(nl); PERIOD_IN = per;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    // Sizes must be latched; scramble the inputs afterwards.
    SIZE_I_IN = W'($urandom_range(0, 9)); SIZE_J_IN = W'($urandom_range(0, 9));
    LENGTH_IN = W'($urandom_range(0, 9)); PERIOD_IN = W'($urandom_range(0, 9));
    pulse_cyc = 0;
    for (int i = 0; i < ni; i++)
      for (int j = 0; j < nj; j++)
        for (int l = 0; l < nl; l++) begin
          x = stim_q.pop_front();
          d = x - prev;
          prev = (l == nl - 1) ? '0 : x;
          exp_q.push_back({(l == nl - 1), (l == nl - 1) && (j == nj - 1), model_div(d, per)});
          acc_q.push_back(cyc + 1);
          DATA_IN = x;
          DATA_IN_SCALAR_ENABLE = 1'b1;
          @(negedge CLK);
          DATA_IN_SCALAR_ENABLE = 1'b0;
          DATA_IN = {$urandom, $urandom};
          if (inject) begin
            repeat (10) @(negedge CLK);
            DATA_IN_SCALAR_ENABLE = 1'b1;
            @(negedge CLK);
            DATA_IN_SCALAR_ENABLE = 1'b0;
          end
          k = 0;
          while (DATA_OUT_SCALAR_ENABLE !== 1'b1 && k < 200) begin
            @(negedge CLK);
            k++;
          end
          if (k >= 200) begin
            checks++; errors++;
            $display("FAIL pulse_timeout: no scalar pulse within 200 cycles, want one");
            return;
          end
          pulse_cyc = cyc;
        end
    k = 0;
    while (READY !== 1'b1 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (READY !== 1'b1 || cyc - pulse_cyc !== 1) begin
      errors++;
      $display("FAIL ready_timing: got ready=%b %0d cycles after last pulse, want 1 after 1",
               READY, cyc - pulse_cyc);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_width: got %b, want 0", READY);
    end
    checks++;
    if (n_out - n0 !== ni * nj * nl || n_ready - r0 !== 1) begin
      errors++;
      $display("FAIL counts: got %0d pulses %0d ready, want %0d pulses 1 ready",
               n_out - n0, n_ready - r0, ni * nj * nl);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if ({READY, DATA_OUT_SCALAR_ENABLE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_MATRIX_ENABLE} !== 4'b0
          || DATA_OUT !== '0) begin
        errors++;
        $display("FAIL reset_idle: got ready=%b en=%b%b%b data=%h, want all 0", READY,
                 DATA_OUT_SCALAR_ENABLE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_MATRIX_ENABLE, DATA_OUT);
      end
    end
  endtask

  task automatic test_basic();
    stim_q = '{64'd2, 64'd6, 64'd6, 64'd0};
    run_tensor(1, 1, 4, 64'd2, 1'b0);
    checks++;
    if (DATA_OUT !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL basic_hold: got %h, want fffffffffffffffd", DATA_OUT);
    end
  endtask

  task automatic test_vector_boundary();
    stim_q = '{64'd4, 64'd8, 64'd10, 64'd10};
    run_tensor(1, 2, 2, 64'd1, 1'b0);
  endtask

  task automatic test_rounding();
    stim_q = '{-64'sd7};
    run_tensor(1, 1, 1, 64'd3, 1'b0);
    checks++;
    if (DATA_OUT !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL trunc_neg: got %h, want fffffffffffffffe", DATA_OUT);
    end
    stim_q = '{64'd5};
    run_tensor(1, 1, 1, 64'd0, 1'b0);
    checks++;
    if (DATA_OUT !== 64'd0) begin
      errors++;
      $display("FAIL period_zero: got %h, want 0", DATA_OUT);
    end
  endtask

  task automatic test_zero_size();
    int n0;
    n0 = n_out;
    SIZE_I_IN = 64'd2; SIZE_J_IN = 64'd2; LENGTH_IN = 64'd0; PERIOD_IN = 64'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if (READY !== 1'b0) begin
      errors++; $display("FAIL zero_ready_early: got %b, want 0", READY);
    end
    @(negedge CLK);
    checks++;
    if (READY !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got %b, want 1", READY);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (READY !== 1'b0 || n_out !== n0) begin
      errors++;
      $display("FAIL zero_after: got ready=%b pulses=%0d, want 0 and 0", READY, n_out - n0);
    end
  endtask

  task automatic test_ignore_enable();
    stim_q = '{64'd3, 64'd9};
    run_tensor(1, 1, 2, 64'd3, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n0, r0;
    n0 = n_out;
    r0 = n_ready;
    SIZE_I_IN = 64'd1; SIZE_J_IN = 64'd1; LENGTH_IN = 64'd4; PERIOD_IN = 64'd2;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    DATA_IN = 64'd2;
    DATA_IN_SCALAR_ENABLE = 1'b1;
    @(negedge CLK);
    DATA_IN_SCALAR_ENABLE = 1'b0;
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({READY, DATA_OUT_SCALAR_ENABLE} !== 2'b0 || DATA_OUT !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b scalar=%b data=%h, want 0",
               READY, DATA_OUT_SCALAR_ENABLE, DATA_OUT);
    end
    repeat (60) @(negedge CLK);
    #1;
    checks++;
    if (n_out !== n0 || n_ready !== r0) begin
      errors++;
      $display("FAIL reset_abort: got %0d pulses %0d ready, want 0 and 0", n_out - n0, n_ready - r0);
    end
    @(negedge CLK);
    RST = 1'b0;
    stim_q = '{64'd2, 64'd6, 64'd6, 64'd0};
    run_tensor(1, 1, 4, 64'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ni, nj, nl;
    logic [W-1:0] per;
    for (int t = 0; t < 3; t++) begin
      ni  = $urandom_range(1, 2);
      nj  = $urandom_range(1, 2);
      nl  = $urandom_range(1, 3);
      per = W'($urandom_range(0, 7));
      for (int k = 0; k < ni * nj * nl; k++)
        stim_q.push_back((t == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 100)) - 64'd50);
      run_tensor(ni, nj, nl, per, 1'b0);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; DATA_IN_SCALAR_ENABLE = 1'b0;
    SIZE_I_IN = '0; SIZE_J_IN = '0; LENGTH_IN = '0; PERIOD_IN = '0; DATA_IN = '0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_vector_boundary();
    test_rounding();
    test_zero_size();
    test_ignore_enable();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
